// File: rtl/vga_timing_controller_pkg.sv
// ---------------------------------------------------------------------------
// vga_timing_controller_pkg
//
// Shared definitions for the VGA timing controller:
//   - the 640x480@60 timing set, used as default parameter values by the top
//   - the controller FSM state encoding
//   - a helper that sums the four segments of a timing axis
// ---------------------------------------------------------------------------
package vga_timing_controller_pkg;

  // 640x480@60 with a 25 MHz-class pixel clock derived from a 2x system clock
  localparam int VGA_CLK_DIV   = 2;
  localparam int VGA_H_DISPLAY = 640;
  localparam int VGA_H_FRONT   = 16;
  localparam int VGA_H_SYNC    = 96;
  localparam int VGA_H_BACK    = 48;
  localparam int VGA_V_DISPLAY = 480;
  localparam int VGA_V_FRONT   = 10;
  localparam int VGA_V_SYNC    = 2;
  localparam int VGA_V_BACK    = 33;
  localparam int VGA_COORD_W   = 10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } vga_state_e;

  // Period of one axis: display + front porch + sync + back porch
  function automatic int axis_total(input int display, input int front,
                                    input int sync, input int back);
    return display + front + sync + back;
  endfunction

endpackage

// File: rtl/vga_timing_controller_timing_axis.sv
// ---------------------------------------------------------------------------
// vga_timing_controller_timing_axis
//
// One timing axis (horizontal or vertical). A counter runs 0..TOTAL-1 and
// advances on CE; CLR forces it back to 0 and holds it there. Sync, visible
// and last are decoded directly from the count register.
//
// Ports:
//   CLK      system clock
//   RESET    synchronous, active-high reset (count -> 0)
//   CE       advance enable (one step per strobe)
//   CLR      hold the counter at 0 (takes priority over CE)
//   count    current position on the axis
//   sync_n   active-low sync, low inside the sync segment
//   visible  high while count is inside the display segment
//   last     high when count is TOTAL-1 (the next CE wraps to 0)
// ---------------------------------------------------------------------------
module vga_timing_controller_timing_axis
  import vga_timing_controller_pkg::*;
#(
  parameter int DISPLAY = 640,
  parameter int FRONT   = 16,
  parameter int SYNC    = 96,
  parameter int BACK    = 48,
  parameter int COUNT_W = 10
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               CE,
  input  logic               CLR,
  output logic [COUNT_W-1:0] count,
  output logic               sync_n,
  output logic               visible,
  output logic               last
);

  localparam int TOTAL = axis_total(DISPLAY, FRONT, SYNC, BACK);

  localparam logic [COUNT_W-1:0] LAST_C       = COUNT_W'(TOTAL - 1);
  localparam logic [COUNT_W-1:0] DISP_C       = COUNT_W'(DISPLAY);
  localparam logic [COUNT_W-1:0] SYNC_START_C = COUNT_W'(DISPLAY + FRONT);
  localparam logic [COUNT_W-1:0] SYNC_END_C   = COUNT_W'(DISPLAY + FRONT + SYNC);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      count <= '0;
    end else if (CLR) begin
      count <= '0;
    end else if (CE) begin
      count <= last ? '0 : count + 1'b1;
    end
  end

  assign last    = (count == LAST_C);
  assign visible = (count < DISP_C);
  assign sync_n  = !((count >= SYNC_START_C) && (count < SYNC_END_C));

endmodule

// File: rtl/vga_timing_controller.sv
// ---------------------------------------------------------------------------
// vga_timing_controller
//
// Generates one VGA frame timeline from the system clock: a pixel-rate
// strobe, horizontal and vertical counters, sync pulses, display enable and
// pixel coordinates. Start and stop requests are only acted on at frame
// boundaries so the downstream display pipeline always sees whole frames.
//
// Ports:
//   CLK          system clock (single domain)
//   RESET        synchronous, active-high reset
//   ENABLE       level run request, sampled on pixel strobes
//   PIX_CE       one-CLK pixel strobe, every CLK_DIV cycles
//   HSYNC        horizontal sync, active low
//   VSYNC        vertical sync, active low
//   DE           display enable, high for visible pixels
//   X, Y         pixel coordinates, 0 whenever DE is low
//   LINE_START   high on the strobe cycle of pixel h=0
//   FRAME_START  high on the strobe cycle of pixel h=0, v=0
//   BUSY         high whenever the controller is not idle
// ---------------------------------------------------------------------------
module vga_timing_controller
  import vga_timing_controller_pkg::*;
#(
  parameter int CLK_DIV   = VGA_CLK_DIV,
  parameter int H_DISPLAY = VGA_H_DISPLAY,
  parameter int H_FRONT   = VGA_H_FRONT,
  parameter int H_SYNC    = VGA_H_SYNC,
  parameter int H_BACK    = VGA_H_BACK,
  parameter int V_DISPLAY = VGA_V_DISPLAY,
  parameter int V_FRONT   = VGA_V_FRONT,
  parameter int V_SYNC    = VGA_V_SYNC,
  parameter int V_BACK    = VGA_V_BACK,
  parameter int COORD_W   = VGA_COORD_W
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               ENABLE,
  output logic               PIX_CE,
  output logic               HSYNC,
  output logic               VSYNC,
  output logic               DE,
  output logic [COORD_W-1:0] X,
  output logic [COORD_W-1:0] Y,
  output logic               LINE_START,
  output logic               FRAME_START,
  output logic               BUSY
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  // -------------------------------------------------------------------------
  // Pixel-rate divider. Free-running, including while idle. The strobe is
  // kept in a register that always equals (div == CLK_DIV-1) for the current
  // cycle, so it is glitch-free and reads 0 straight out of reset.
  // -------------------------------------------------------------------------
  logic [DIV_W-1:0] div;
  logic [DIV_W-1:0] div_nxt;
  logic             pix_ce;

  always_comb begin
    div_nxt = (div == DIV_LAST) ? '0 : div + 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      div    <= '0;
      pix_ce <= 1'b0;
    end else begin
      div    <= div_nxt;
      pix_ce <= (div_nxt == DIV_LAST);
    end
  end

  // -------------------------------------------------------------------------
  // Horizontal and vertical axes. Both are held at 0 while idle; the vertical
  // axis steps once per line, on the strobe that wraps the horizontal axis.
  // -------------------------------------------------------------------------
  logic [COORD_W-1:0] h;
  logic [COORD_W-1:0] v;
  logic               h_sync_n;
  logic               v_sync_n;
  logic               h_vis;
  logic               v_vis;
  logic               h_last;
  logic               v_last;
  logic               busy;
  logic               axis_clr;
  logic               v_ce;

  assign axis_clr = !busy;
  assign v_ce     = pix_ce && h_last;

  vga_timing_controller_timing_axis #(
    .DISPLAY (H_DISPLAY),
    .FRONT   (H_FRONT),
    .SYNC    (H_SYNC),
    .BACK    (H_BACK),
    .COUNT_W (COORD_W)
  ) u_h_axis (
    .CLK     (CLK),
    .RESET   (RESET),
    .CE      (pix_ce),
    .CLR     (axis_clr),
    .count   (h),
    .sync_n  (h_sync_n),
    .visible (h_vis),
    .last    (h_last)
  );

  vga_timing_controller_timing_axis #(
    .DISPLAY (V_DISPLAY),
    .FRONT   (V_FRONT),
    .SYNC    (V_SYNC),
    .BACK    (V_BACK),
    .COUNT_W (COORD_W)
  ) u_v_axis (
    .CLK     (CLK),
    .RESET   (RESET),
    .CE      (v_ce),
    .CLR     (axis_clr),
    .count   (v),
    .sync_n  (v_sync_n),
    .visible (v_vis),
    .last    (v_last)
  );

  // -------------------------------------------------------------------------
  // Run control. Decisions are only taken on pixel strobes, so ENABLE pulses
  // that fall between strobes have no effect. busy is registered alongside
  // the state and is high exactly when the state is not IDLE.
  // -------------------------------------------------------------------------
  vga_state_e state;
  logic       frame_last;

  assign frame_last = h_last && v_last;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= ST_IDLE;
      busy  <= 1'b0;
    end else if (pix_ce) begin
      case (state)
        ST_IDLE: begin
          if (ENABLE) begin
            state <= ST_RUN;
            busy  <= 1'b1;
          end
        end
        ST_RUN: begin
          // A stop request landing on the last pixel is already at the frame
          // boundary, so there is nothing left to drain.
          if (!ENABLE) begin
            if (frame_last) begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end else begin
              state <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (ENABLE) begin
            state <= ST_RUN;
          end else if (frame_last) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Output decode from the current counters; everything is forced to its
  // inactive level while idle.
  // -------------------------------------------------------------------------
  always_comb begin
    DE          = busy && h_vis && v_vis;
    HSYNC       = busy ? h_sync_n : 1'b1;
    VSYNC       = busy ? v_sync_n : 1'b1;
    X           = DE ? h : '0;
    Y           = DE ? v : '0;
    LINE_START  = pix_ce && busy && (h == '0);
    FRAME_START = LINE_START && (v == '0);
  end

  assign PIX_CE = pix_ce;
  assign BUSY   = busy;

endmodule

// File: tb/tb_vga_timing_controller.sv
`timescale 1ns/1ps
module tb_vga_timing_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Small-geometry DUT: CLK_DIV=2, H=4/1/2/1 (8), V=3/1/1/1 (6)
  logic       rst = 1'b1;
  logic       en  = 1'b0;
  logic       pix_ce, hsync, vsync, de, line_start, frame_start, busy;
  logic [9:0] x, y;

  // Default 640x480 DUT with CLK_DIV=1
  logic       rst2 = 1'b1;
  logic       en2  = 1'b0;
  logic       pix_ce_b, hsync_b, vsync_b, de_b, line_start_b, frame_start_b, busy_b;
  logic [9:0] x_b, y_b;

  vga_timing_controller #(
    .CLK_DIV(2), .H_DISPLAY(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
    .V_DISPLAY(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1), .COORD_W(10)
  ) dut (
    .CLK(clk), .RESET(rst), .ENABLE(en), .PIX_CE(pix_ce), .HSYNC(hsync),
    .VSYNC(vsync), .DE(de), .X(x), .Y(y), .LINE_START(line_start),
    .FRAME_START(frame_start), .BUSY(busy)
  );

  vga_timing_controller #(.CLK_DIV(1)) dut2 (
    .CLK(clk), .RESET(rst2), .ENABLE(en2), .PIX_CE(pix_ce_b), .HSYNC(hsync_b),
    .VSYNC(vsync_b), .DE(de_b), .X(x_b), .Y(y_b), .LINE_START(line_start_b),
    .FRAME_START(frame_start_b), .BUSY(busy_b)
  );

  typedef struct packed {
    logic       busy;
    logic       hs;
    logic       vs;
    logic       de;
    logic [9:0] x;
    logic [9:0] y;
    logic       ls;
    logic       fs;
  } pix_t;

  typedef struct {
    pix_t p;
    int   gap;   // expected CLKs since previous FRAME_START, 0 = unchecked
    int   tag;
  } exp_t;

  typedef struct {
    int gap;
    int hs_lo;
    int de_hi;
    int vs_lo;
    int pce;
    int y;
    int x_max;
  } line_t;

  exp_t  q[$];
  line_t q2[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  int    tag_id   = 0;

  // ---------------------------------------------------------------- helpers
  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_pix(input string name, input int tag, input pix_t act, input pix_t exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s #%0d: got busy=%b hs=%b vs=%b de=%b x=%0d y=%0d ls=%b fs=%b, expected busy=%b hs=%b vs=%b de=%b x=%0d y=%0d ls=%b fs=%b",
               name, tag, act.busy, act.hs, act.vs, act.de, act.x, act.y, act.ls, act.fs,
               exp.busy, exp.hs, exp.vs, exp.de, exp.x, exp.y, exp.ls, exp.fs);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timed out waiting for the DUT", name);
  endtask

  // Expected outputs for pixel (h,v) of the 8x6 geometry: HSYNC low at h=5,6,
  // VSYNC low at v=4, visible area 4x3.
  function automatic pix_t expect_pix(input bit run, input int h, input int v);
    pix_t p;
    p    = '0;
    p.hs = 1'b1;
    p.vs = 1'b1;
    if (run) begin
      p.busy = 1'b1;
      p.hs   = !(h == 5 || h == 6);
      p.vs   = (v != 4);
      p.de   = (h < 4) && (v < 3);
      p.x    = p.de ? 10'(h) : 10'd0;
      p.y    = p.de ? 10'(v) : 10'd0;
      p.ls   = (h == 0);
      p.fs   = (h == 0) && (v == 0);
    end
    return p;
  endfunction

  task automatic push_idle(input int n);
    for (int i = 0; i < n; i++) begin
      q.push_back('{p: expect_pix(1'b0, 0, 0), gap: 0, tag: tag_id});
      tag_id++;
    end
  endtask

  task automatic push_frame(input int first_gap, input int npix);
    for (int i = 0; i < npix; i++) begin
      q.push_back('{p: expect_pix(1'b1, i % 8, i / 8), gap: (i == 0) ? first_gap : 0, tag: tag_id});
      tag_id++;
    end
  endtask

  // Advance to the falling edge of the next PIX_CE cycle
  task automatic align();
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!pix_ce && k < 16);
    if (!pix_ce) timeout_fail("pix_ce_wait");
  endtask

  task automatic wait_pix(input int n);
    for (int i = 0; i < n; i++) align();
  endtask

  task automatic drain(input int limit);
    for (int i = 0; i < limit && q.size() != 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      timeout_fail("scoreboard_drain");
      q.delete();
    end
  endtask

  // ---------------------------------------------------------------- monitor
  int   cyc      = 0;
  int   last_pix = 0;
  int   last_fs  = 0;
  bit   seen_pix = 1'b0;
  pix_t act_p;
  pix_t hold_p;
  exp_t e;

  always @(posedge clk) begin
    #1;
    cyc++;
    if (rst) seen_pix = 1'b0;
    act_p = {busy, hsync, vsync, de, x, y, line_start, frame_start};
    if (q.size() > 0) begin
      if (pix_ce) begin
        e = q.pop_front();
        check_pix("pixel", e.tag, act_p, e.p);
        if (seen_pix) check_int("pix_ce_period", cyc - last_pix, 2);
        if (frame_start && e.gap != 0) check_int("frame_start_spacing", cyc - last_fs, e.gap);
      end else begin
        hold_p    = q[0].p;
        hold_p.ls = 1'b0;
        hold_p.fs = 1'b0;
        check_pix("between_strobes", q[0].tag, act_p, hold_p);
      end
    end
    if (pix_ce) begin
      seen_pix = 1'b1;
      last_pix = cyc;
    end
    if (frame_start) last_fs = cyc;
  end

  // Line-level monitor for the full-size, undivided instance
  bit    seen2 = 1'b0;
  int    cnt2, hs_lo2, de_hi2, vs_lo2, pce2, y_cap2, x_max2;
  line_t l2;

  always @(posedge clk) begin
    #1;
    if (rst2) begin
      seen2 = 1'b0;
    end else if (line_start_b) begin
      if (!seen2) begin
        if (q2.size() > 0) check_int("dut2_first_line_frame_start", int'(frame_start_b), 1);
      end else if (q2.size() > 0) begin
        l2 = q2.pop_front();
        check_int("dut2_line_clks", cnt2, l2.gap);
        check_int("dut2_hsync_low_clks", hs_lo2, l2.hs_lo);
        check_int("dut2_de_clks", de_hi2, l2.de_hi);
        check_int("dut2_vsync_low_clks", vs_lo2, l2.vs_lo);
        check_int("dut2_pix_ce_clks", pce2, l2.pce);
        check_int("dut2_line_y", y_cap2, l2.y);
        check_int("dut2_line_x_max", x_max2, l2.x_max);
        check_int("dut2_busy", int'(busy_b), 1);
      end
      seen2  = 1'b1;
      cnt2   = 1;
      hs_lo2 = int'(!hsync_b);
      de_hi2 = int'(de_b);
      vs_lo2 = int'(!vsync_b);
      pce2   = int'(pix_ce_b);
      y_cap2 = de_b ? int'(y_b) : -1;
      x_max2 = de_b ? int'(x_b) : -1;
    end else begin
      cnt2++;
      hs_lo2 += int'(!hsync_b);
      de_hi2 += int'(de_b);
      vs_lo2 += int'(!vsync_b);
      pce2   += int'(pix_ce_b);
      if (de_b) begin
        y_cap2 = int'(y_b);
        if (int'(x_b) > x_max2) x_max2 = int'(x_b);
      end
    end
  end

  // --------------------------------------------------------------- stimulus
  initial begin
    // Reset state, then idle with a stray ENABLE pulse between strobes
    @(negedge clk);
    @(negedge clk);
    push_idle(10);
    @(negedge clk);
    rst = 1'b0;
    align();
    @(negedge clk);
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    drain(100);

    // Three frames; stop requested at h=3,v=1 of the third, which completes
    align();
    en = 1'b1;
    push_frame(0, 48);
    push_frame(96, 48);
    push_frame(96, 48);
    push_idle(4);
    wait_pix(108);
    en = 1'b0;
    drain(400);

    // Stop at h=2,v=3 then resume at h=6,v=4 of the same frame
    align();
    en = 1'b1;
    push_frame(0, 48);
    push_frame(96, 14);
    wait_pix(27);
    en = 1'b0;
    wait_pix(12);
    en = 1'b1;
    wait_pix(23);

    // Reset for one CLK while HSYNC is low (pixel h=6, v=1), ENABLE held high
    @(negedge clk);
    push_idle(1);
    push_frame(0, 48);
    push_idle(3);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    wait_pix(33);
    en = 1'b0;
    drain(300);
    check_int("scoreboard_empty", q.size(), 0);

    // Undivided clock, 640x480 timing: three full lines
    for (int i = 0; i < 3; i++)
      q2.push_back('{gap: 800, hs_lo: 96, de_hi: 640, vs_lo: 0, pce: 800, y: i, x_max: 639});
    @(negedge clk);
    rst2 = 1'b0;
    en2  = 1'b1;
    for (int i = 0; i < 5000 && q2.size() != 0; i++) @(negedge clk);
    if (q2.size() != 0) timeout_fail("dut2_line_drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule
